// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequence checker: FSM state encoding and
// default widths for the observed count, wrap epoch and error counter.
package count_seq_pkg;

  localparam int CNT_W    = 5;
  localparam int EPOCH_W  = 8;
  localparam int ERRCNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear that coincides with an
// increment yields 1 so the new event is never lost.
module sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? WIDTH'(1) : '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/count_seq_checker.sv
// Watches an upstream free-running counter: syncs on the first zero, flags
// every break in the +1 sequence, and counts legal all-ones-to-zero wraps.
//
// state    | meaning
// ST_IDLE  | waiting for the first zero after reset
// ST_TRACK | in sync, each sample must equal prev + 1
// ST_ERROR | sequence broken, waiting for a zero to resync
module count_seq_checker
  import count_seq_pkg::state_e;
  import count_seq_pkg::ST_IDLE;
  import count_seq_pkg::ST_TRACK;
  import count_seq_pkg::ST_ERROR;
#(
  parameter int CNT_W    = count_seq_pkg::CNT_W,
  parameter int EPOCH_W  = count_seq_pkg::EPOCH_W,
  parameter int ERRCNT_W = count_seq_pkg::ERRCNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CNT_W-1:0]    count,
  input  logic                err_clr,
  output logic                in_sync,
  output logic                wrap_pulse,
  output logic [EPOCH_W-1:0]  epoch,
  output logic                seq_err,
  output logic                err_sticky,
  output logic [ERRCNT_W-1:0] err_cnt
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   prev_q;
  logic [CNT_W-1:0]   expected;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               in_sync_q, wrap_q, wrap_d, seq_err_q, viol;
  logic               sticky_q, sticky_d;

  assign expected = prev_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    wrap_d   = 1'b0;
    viol     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (count == '0) state_d = ST_TRACK;
      end
      ST_TRACK: begin
        // A matching zero can only follow all-ones, so it is always a legal wrap.
        if (count == expected) begin
          wrap_d = (count == '0);
        end else begin
          viol    = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        if (count == '0) state_d = ST_TRACK;
      end
      default: state_d = ST_IDLE;
    endcase

    epoch_d = wrap_d ? (epoch_q + EPOCH_W'(1)) : epoch_q;

    sticky_d = sticky_q;
    if (viol) begin
      sticky_d = 1'b1;
    end else if (err_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      prev_q    <= '0;
      epoch_q   <= '0;
      in_sync_q <= 1'b0;
      wrap_q    <= 1'b0;
      seq_err_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= count;
      epoch_q   <= epoch_d;
      in_sync_q <= (state_d == ST_TRACK);
      wrap_q    <= wrap_d;
      seq_err_q <= viol;
      sticky_q  <= sticky_d;
    end
  end

  sat_counter #(
    .WIDTH (ERRCNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (viol),
    .clr   (err_clr),
    .cnt   (err_cnt)
  );

  assign in_sync    = in_sync_q;
  assign wrap_pulse = wrap_q;
  assign epoch      = epoch_q;
  assign seq_err    = seq_err_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: directed scenarios plus randomized count streams,
// checked every cycle against a behavioural model of the sequence rules.
module tb_count_seq_checker;

  localparam int CNT_W    = 5;
  localparam int EPOCH_W  = 8;
  localparam int ERRCNT_W = 4;
  localparam int CMOD     = 1 << CNT_W;
  localparam int EMOD     = 1 << EPOCH_W;
  localparam int EMAX     = (1 << ERRCNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [CNT_W-1:0]    count;
  logic                err_clr;
  logic                in_sync;
  logic                wrap_pulse;
  logic [EPOCH_W-1:0]  epoch;
  logic                seq_err;
  logic                err_sticky;
  logic [ERRCNT_W-1:0] err_cnt;

  count_seq_checker #(
    .CNT_W    (CNT_W),
    .EPOCH_W  (EPOCH_W),
    .ERRCNT_W (ERRCNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .count      (count),
    .err_clr    (err_clr),
    .in_sync    (in_sync),
    .wrap_pulse (wrap_pulse),
    .epoch      (epoch),
    .seq_err    (seq_err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: synced / broken flags, last sample, and expected output values.
  bit m_synced, m_broken, m_seen_zero;
  int m_prev, m_epoch, m_err;
  bit m_sticky, m_wrap, m_serr;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_synced = 0; m_broken = 0; m_seen_zero = 0;
    m_prev = 0; m_epoch = 0; m_err = 0;
    m_sticky = 0; m_wrap = 0; m_serr = 0;
  endtask

  task automatic model_edge(input int c, input bit clr);
    m_wrap = 0;
    m_serr = 0;
    if (m_synced) begin
      if (c == (m_prev + 1) % CMOD) begin
        m_wrap = (c == 0);
      end else begin
        m_serr   = 1;
        m_synced = 0;
        m_broken = 1;
      end
    end else if (c == 0) begin
      m_synced = 1;
      m_broken = 0;
    end
    if (m_wrap) m_epoch = (m_epoch + 1) % EMOD;
    if (m_serr) begin
      m_err    = clr ? 1 : ((m_err < EMAX) ? m_err + 1 : EMAX);
      m_sticky = 1;
    end else if (clr) begin
      m_err    = 0;
      m_sticky = 0;
    end
    m_prev = c;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_sync",    int'(in_sync),    int'(m_synced));
      chk("wrap_pulse", int'(wrap_pulse), int'(m_wrap));
      chk("seq_err",    int'(seq_err),    int'(m_serr));
      chk("epoch",      int'(epoch),      m_epoch);
      chk("err_cnt",    int'(err_cnt),    m_err);
      chk("err_sticky", int'(err_sticky), int'(m_sticky));
      chk("wrap_and_err_exclusive", int'(wrap_pulse & seq_err), 0);
    end
  end

  task automatic step(input int c, input bit clr = 1'b0);
    count   = CNT_W'(c);
    err_clr = clr;
    @(posedge clk);
    if (rst_n) model_edge(c, clr);
    else       model_reset();
    #1;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_in_sync"},    int'(in_sync),    0);
    chk({nm, "_wrap_pulse"}, int'(wrap_pulse), 0);
    chk({nm, "_epoch"},      int'(epoch),      0);
    chk({nm, "_seq_err"},    int'(seq_err),    0);
    chk({nm, "_err_sticky"}, int'(err_sticky), 0);
    chk({nm, "_err_cnt"},    int'(err_cnt),    0);
  endtask

  // Asserts reset between edges, holds it across one edge sampling c, then releases.
  task automatic do_reset(input int c);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("reset_async");
    step(c);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, r;
    bit clr;
    model_reset();
    rst_n   = 1'b0;
    count   = '0;
    err_clr = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("reset_initial");
    chk_en = 1'b1;
    step(0);
    rst_n = 1'b1;

    // Clean run 0..31,0,1 from reset
    for (int i = 0; i < 32; i++) begin
      step(i);
      if (i == 0) chk("first_zero_in_sync", int'(in_sync), 1);
    end
    chk("no_wrap_before_second_zero", int'(epoch), 0);
    step(0);
    chk("wrap_after_second_zero", int'(wrap_pulse), 1);
    chk("epoch_after_one_wrap", int'(epoch), 1);
    step(1);
    chk("wrap_single_cycle", int'(wrap_pulse), 0);
    chk("err_cnt_clean_run", int'(err_cnt), 0);

    // Start mid-range after reset: no sync until a zero
    do_reset(3);
    for (int i = 7; i < 32; i++) step(i);
    chk("late_start_no_sync", int'(in_sync), 0);
    step(0);
    chk("late_start_sync_on_zero", int'(in_sync), 1);
    chk("late_start_no_wrap", int'(wrap_pulse), 0);
    chk("late_start_no_err", int'(seq_err), 0);

    // Jump 4,5,9 in TRACK
    for (int i = 1; i <= 5; i++) step(i);
    step(9);
    chk("jump_seq_err", int'(seq_err), 1);
    chk("jump_err_cnt", int'(err_cnt), 1);
    chk("jump_sticky", int'(err_sticky), 1);
    chk("jump_in_sync", int'(in_sync), 0);
    step(10);
    chk("error_no_repeat_err", int'(seq_err), 0);
    step(0);
    chk("resync_in_sync", int'(in_sync), 1);
    chk("resync_no_wrap", int'(wrap_pulse), 0);
    chk("resync_epoch_kept", int'(epoch), 0);

    // 20 violation/resync cycles drive err_cnt into saturation
    for (int k = 0; k < 20; k++) begin
      step(5);
      step(0);
    end
    chk("err_cnt_saturated", int'(err_cnt), EMAX);
    step(1, 1'b1);
    chk("clr_err_cnt", int'(err_cnt), 0);
    chk("clr_sticky", int'(err_sticky), 0);
    chk("clr_keeps_sync", int'(in_sync), 1);

    // err_clr together with a held-count violation
    step(2);
    step(3);
    step(3, 1'b1);
    chk("clr_vs_viol_err_cnt", int'(err_cnt), 1);
    chk("clr_vs_viol_sticky", int'(err_sticky), 1);
    chk("held_count_seq_err", int'(seq_err), 1);

    // Reset mid-TRACK at 17, count keeps running
    step(0);
    for (int i = 1; i <= 17; i++) step(i);
    do_reset(18);
    for (int i = 19; i < 32; i++) step(i);
    chk("post_reset_no_sync", int'(in_sync), 0);
    step(0);
    chk("post_reset_sync", int'(in_sync), 1);
    chk("post_reset_no_wrap", int'(wrap_pulse), 0);

    // Long clean run: epoch wraps 255 -> 0 silently
    for (int w = 0; w < 260; w++) begin
      for (int i = 1; i < 32; i++) step(i);
      step(0);
    end
    chk("epoch_wrapped", int'(epoch), 260 % EMOD);
    chk("long_run_no_errors", int'(err_cnt), 0);

    // Randomized streams: mostly incrementing with jumps, holds, zeros, clears, resets
    c = 0;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4)       c = int'($urandom_range(0, CMOD - 1));
      else if (r < 7)  c = c;
      else if (r < 9)  c = 0;
      else             c = (c + 1) % CMOD;
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 299) == 0) do_reset(c);
      else                             step(c, clr);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
